alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor of the combinational datapath ALU.
//  - Executes one command per transaction: pass/xor/compare/add/load-immediate/parity.
//  - Shifts run iteratively, one bit per cycle, bounding the shifter to a 1-bit stage.
//  - Sits between the register-file read stage and the writeback/branch unit.
//  - Results and flags are registered and held until consumed.
// PARAMETERS
//  W      8   datapath width in bits (>= 2)
//  CMD_W  4   command field width
//  SA_W   $clog2(W)  shift-amount field width (derived, not overridable)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high
//  in_valid     in   1      command/operands present
//  in_ready     out  1      block accepts command this cycle
//  alu_cmd      in   CMD_W  operation select
//  inA          in   W      operand A / shift amount
//  inB          in   W      operand B / shift data / immediate
//  sc_i         in   1      carry-in for add
//  out_valid    out  1      result registers valid
//  out_ready    in   1      consumer takes result this cycle
//  rslt         out  W      result
//  sc_o         out  1      carry out (add) / last bit shifted out (shifts)
//  pari         out  1      ^rslt of the presented result
//  branch_bool  out  1      1 only for bne with inA != inB
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rslt, sc_o, pari, branch_bool, out_valid, busy = 0; in-flight op dropped.
//  Accept: in_valid && in_ready at a rising edge; operands are captured and never re-sampled.
//  in_ready = (state==IDLE) || (state==DONE && out_ready), which allows back-to-back issue.
//  States: IDLE -(accept, 1-cycle op or shift amt 0)-> DONE; IDLE -(accept, shift amt k>=1)-> SHIFT.
//  SHIFT: decrements counter each cycle; enters DONE after k shift cycles.
//  DONE: out_valid=1; outputs stable while !out_ready.
//  DONE + out_ready + accept: reload, as from IDLE. DONE + out_ready, no accept: IDLE.
//  Latency: 1-cycle ops give out_valid the cycle after accept.
//  Latency: a shift of k gives out_valid k+1 cycles after accept.
//  Commands (unlisted codes: rslt=0, sc_o=0, 1-cycle):
//   0 load, 1 store, 5 mov: rslt=inA
//   2 xor: rslt=inA^inB
//   3 bne: rslt={0..,(inA!=inB)}, branch_bool=(inA!=inB)
//   4 add: {sc_o,rslt}=inA+inB+sc_i, computed W+1 bits wide; wraps mod 2^W
//   6 lshift: rslt=inB<<amt, zero fill
//   7 rshift: rslt=inB>>amt, logical, zero fill
//   8 loadi: rslt=inB
//   9 pari: rslt={0..,^inA}
//  Shift amount: amt=inA[SA_W-1:0].
//   - If any bit of inA above SA_W is set: rslt=0, sc_o=0, 1-cycle.
//   - amt=0: rslt=inB, sc_o=0.
//   - Otherwise sc_o is the bit shifted out on the final shift cycle.
//  branch_bool=0 for every command other than 3.
//  pari is computed from the final rslt and registered with it.
//  busy=1 in SHIFT and DONE.
//  Reset asserted in SHIFT/DONE: IDLE next cycle, no out_valid pulse.
// TESTING
//  1. Reset, then xor A=8'hF0 B=8'h3C -> out_valid 1 cycle later; rslt=8'hCC, pari=0.
//  2. add A=8'hFF B=8'h01 sc_i=1 -> rslt=8'h01, sc_o=1; A=8'h10 B=8'h20 sc_i=0 -> 8'h30, sc_o=0.
//  3. lshift A=3 B=8'hB1 -> in_ready=0 for 3 cycles; out_valid 4 cycles after accept; rslt=8'h88, sc_o=1.
//     rshift A=8'h09 -> rslt=0, sc_o=0, 1-cycle.
//  4. bne A=5 B=5 -> branch_bool=0, rslt=0; A=5 B=6 -> branch_bool=1, rslt=1.
//  5. Hold out_ready=0 for 5 cycles after add -> outputs stable, in_ready=0.
//     Then out_ready=1 with a new valid -> accepted same cycle, next result next cycle.
//  6. Assert reset mid rshift A=6 -> IDLE, all outputs 0, no out_valid.
//     W=16 regression: lshift A=15 B=16'h0001 -> rslt=16'h8000.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential, handshaked ALU. Single-cycle commands finish on the accept edge.
// Shifts are done iteratively through a 1-bit stage, one position per cycle.
// Results and flags are registered and held in DONE until the consumer takes them.
module alu_seq #(
  parameter int W     = 8,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic             sc_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     rslt,
  output logic             sc_o,
  output logic             pari,
  output logic             branch_bool,
  output logic             busy
);

  localparam int SA_W = $clog2(W);

  localparam logic [CMD_W-1:0] CMD_LOAD  = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_STORE = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_XOR   = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_BNE   = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_ADD   = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_MOV   = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_LSH   = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_RSH   = CMD_W'(7);
  localparam logic [CMD_W-1:0] CMD_LOADI = CMD_W'(8);
  localparam logic [CMD_W-1:0] CMD_PARI  = CMD_W'(9);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [W-1:0]      r_rslt;
  logic              r_sc;
  logic              r_pari;
  logic              r_bb;
  logic [W-1:0]      r_sh;
  logic [SA_W-1:0]   r_cnt;
  logic              r_left;

  logic              w_accept;
  logic [SA_W-1:0]   w_amt;
  logic              w_amt_hi;
  logic              w_is_shift;
  logic              w_start_shift;
  logic [W-1:0]      w_rslt;
  logic              w_sc;
  logic              w_bb;
  logic [W-1:0]      w_sh_next;
  logic              w_sh_out;
  logic              w_last;

  assign w_accept      = in_valid && in_ready;
  assign w_amt         = inA[SA_W-1:0];
  assign w_amt_hi      = |(inA >> SA_W);
  assign w_is_shift    = (alu_cmd == CMD_LSH) || (alu_cmd == CMD_RSH);
  assign w_start_shift = w_is_shift && !w_amt_hi && (w_amt != '0);
  assign w_last        = (r_cnt == SA_W'(1));

  // Single-cycle result for the command presented at the inputs.
  always_comb begin
    w_rslt = '0;
    w_sc   = 1'b0;
    w_bb   = 1'b0;
    case (alu_cmd)
      CMD_LOAD, CMD_STORE, CMD_MOV: w_rslt = inA;
      CMD_XOR:   w_rslt = inA ^ inB;
      CMD_BNE: begin
        w_bb      = (inA != inB);
        w_rslt[0] = (inA != inB);
      end
      CMD_ADD:   {w_sc, w_rslt} = {1'b0, inA} + {1'b0, inB} + (W+1)'(sc_i);
      CMD_LSH, CMD_RSH: begin
        // Only the amt=0 case resolves here; out-of-range amounts yield 0.
        if (!w_amt_hi && (w_amt == '0)) w_rslt = inB;
      end
      CMD_LOADI: w_rslt = inB;
      CMD_PARI:  w_rslt[0] = ^inA;
      default: ;
    endcase
  end

  // One-position shift step and the bit it pushes out.
  always_comb begin
    if (r_left) begin
      w_sh_next = {r_sh[W-2:0], 1'b0};
      w_sh_out  = r_sh[W-1];
    end else begin
      w_sh_next = {1'b0, r_sh[W-1:1]};
      w_sh_out  = r_sh[0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  // Operand capture, shift iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rslt <= '0;
      r_sc   <= 1'b0;
      r_pari <= 1'b0;
      r_bb   <= 1'b0;
      r_sh   <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
    end else if (w_accept) begin
      r_sh   <= inB;
      r_cnt  <= w_amt;
      r_left <= (alu_cmd == CMD_LSH);
      if (!w_start_shift) begin
        r_rslt <= w_rslt;
        r_sc   <= w_sc;
        r_pari <= ^w_rslt;
        r_bb   <= w_bb;
      end
    end else if (r_state == S_SHIFT) begin
      r_sh  <= w_sh_next;
      r_cnt <= r_cnt - SA_W'(1);
      if (w_last) begin
        r_rslt <= w_sh_next;
        r_sc   <= w_sh_out;
        r_pari <= ^w_sh_next;
        r_bb   <= 1'b0;
      end
    end
  end

  assign rslt        = r_rslt;
  assign sc_o        = r_sc;
  assign pari        = r_pari;
  assign branch_bool = r_bb;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written handshake/reset
// sequences, randomized transactions against an arithmetic reference model,
// and a W=16 long-shift regression.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] alu_cmd = '0;
  logic [7:0] inA = '0;
  logic [7:0] inB = '0;
  logic       sc_i = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] rslt;
  logic       sc_o, pari, branch_bool, busy;

  logic        v16_in_valid = 1'b0;
  logic        v16_in_ready;
  logic [3:0]  v16_cmd = '0;
  logic [15:0] v16_a = '0;
  logic [15:0] v16_b = '0;
  logic        v16_out_valid;
  logic [15:0] v16_rslt;
  logic        v16_sc, v16_pari, v16_bb, v16_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(8), .CMD_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt), .sc_o(sc_o),
    .pari(pari), .branch_bool(branch_bool), .busy(busy)
  );

  alu_seq #(.W(16), .CMD_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v16_in_valid), .in_ready(v16_in_ready),
    .alu_cmd(v16_cmd), .inA(v16_a), .inB(v16_b), .sc_i(1'b0),
    .out_valid(v16_out_valid), .out_ready(1'b1), .rslt(v16_rslt), .sc_o(v16_sc),
    .pari(v16_pari), .branch_bool(v16_bb), .busy(v16_busy)
  );

  typedef struct {
    int cmd; int a; int b; bit ci;
    int r; bit sc; bit p; bit bb; int lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on an 8-bit datapath.
  function automatic vec_t model(int cmd, int a, int b, bit ci);
    vec_t v;
    int s;
    v.cmd = cmd; v.a = a; v.b = b; v.ci = ci;
    v.r = 0; v.sc = 0; v.bb = 0; v.lat = 1;
    case (cmd)
      0, 1, 5: v.r = a;
      2: v.r = a ^ b;
      3: begin v.bb = (a != b); v.r = (a != b) ? 1 : 0; end
      4: begin s = a + b + int'(ci); v.r = s % 256; v.sc = ((s / 256) % 2) == 1; end
      6, 7: begin
        if (a >= 8) v.r = 0;
        else if (a == 0) v.r = b;
        else begin
          v.lat = a + 1;
          if (cmd == 6) begin
            s = b * (2 ** a);
            v.r = s % 256;
            v.sc = ((s / 256) % 2) == 1;
          end else begin
            v.r = b / (2 ** a);
            v.sc = ((b / (2 ** (a - 1))) % 2) == 1;
          end
        end
      end
      8: v.r = b;
      9: v.r = $countones(a) % 2;
      default: v.r = 0;
    endcase
    v.p = ($countones(v.r) % 2) == 1;
    return v;
  endfunction

  // Issue one transaction, wait for its result, compare, optionally stall the consumer.
  task automatic run_vec(input vec_t v, input int stall, input string tag);
    int lat;
    int nrdy;
    @(negedge clk);
    alu_cmd = v.cmd[3:0]; inA = v.a[7:0]; inB = v.b[7:0]; sc_i = v.ci;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inA = 8'($urandom); inB = 8'($urandom); sc_i = 1'($urandom); alu_cmd = 4'($urandom);
    lat = 0; nrdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && !in_ready) nrdy++;
    end while (!out_valid && lat < 64);
    if (!out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL %s.timeout: out_valid not seen after %0d cycles", tag, lat);
    end else begin
      chk({tag, ".latency"}, 32'(lat), 32'(v.lat));
      chk({tag, ".not_ready_cycles"}, 32'(nrdy), 32'(v.lat - 1));
      chk({tag, ".rslt"}, 32'(rslt), 32'(v.r));
      chk({tag, ".sc_o"}, 32'(sc_o), 32'(v.sc));
      chk({tag, ".pari"}, 32'(pari), 32'(v.p));
      chk({tag, ".branch_bool"}, 32'(branch_bool), 32'(v.bb));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".hold_rslt"}, 32'(rslt), 32'(v.r));
        chk({tag, ".hold_sc"}, 32'(sc_o), 32'(v.sc));
        chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
  endtask

  vec_t tbl[18];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    int cnt;
    int cmd, a, b, stall;

    //              cmd  a      b      ci  r      sc p  bb lat
    tbl = '{
      '{2,   'hF0,  'h3C,  0,  'hCC,  0, 0, 0, 1},
      '{4,   'hFF,  'h01,  1,  'h01,  1, 1, 0, 1},
      '{4,   'h10,  'h20,  0,  'h30,  0, 0, 0, 1},
      '{6,   3,     'hB1,  0,  'h88,  1, 0, 0, 4},
      '{7,   'h09,  'hFF,  0,  0,     0, 0, 0, 1},
      '{3,   5,     5,     0,  0,     0, 0, 0, 1},
      '{3,   5,     6,     0,  1,     0, 1, 1, 1},
      '{8,   0,     'hA5,  0,  'hA5,  0, 0, 0, 1},
      '{9,   'h07,  0,     0,  1,     0, 1, 0, 1},
      '{5,   'h3C,  'hFF,  0,  'h3C,  0, 0, 0, 1},
      '{0,   'h81,  0,     0,  'h81,  0, 0, 0, 1},
      '{1,   'h7F,  0,     0,  'h7F,  0, 1, 0, 1},
      '{15,  'hAA,  'h55,  1,  0,     0, 0, 0, 1},
      '{7,   0,     'h5A,  0,  'h5A,  0, 0, 0, 1},
      '{7,   2,     'h06,  0,  1,     1, 1, 0, 3},
      '{6,   7,     'h03,  0,  'h80,  1, 1, 0, 8},
      '{4,   'h80,  'h80,  0,  0,     1, 0, 0, 1},
      '{6,   8,     'hFF,  0,  0,     0, 0, 0, 1}
    };

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset.rslt", 32'(rslt), 32'd0);
    chk("reset.sc_o", 32'(sc_o), 32'd0);
    chk("reset.pari", 32'(pari), 32'd0);
    chk("reset.branch_bool", 32'(branch_bool), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Directed table.
    foreach (tbl[i]) run_vec(tbl[i], 0, $sformatf("tbl%0d", i));

    // Consumer stall after add, then back-to-back accept from DONE.
    @(negedge clk);
    alu_cmd = 4'd4; inA = 8'hFF; inB = 8'h01; sc_i = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stall.valid0", 32'(out_valid), 32'd1);
    chk("stall.rslt0", 32'(rslt), 32'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.rslt", 32'(rslt), 32'h01);
      chk("stall.sc_o", 32'(sc_o), 32'd1);
      chk("stall.valid", 32'(out_valid), 32'd1);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    alu_cmd = 4'd2; inA = 8'hF0; inB = 8'h3C; sc_i = 1'b0;
    #1;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b.valid", 32'(out_valid), 32'd1);
    chk("b2b.rslt", 32'(rslt), 32'hCC);
    chk("b2b.pari", 32'(pari), 32'd0);

    // Randomized transactions against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) cmd = 6 + int'($urandom_range(0, 1));
      else cmd = int'($urandom_range(0, 15));
      if ((cmd == 6 || cmd == 7) && $urandom_range(0, 3) != 0) a = int'($urandom_range(0, 8));
      else a = int'($urandom_range(0, 255));
      b = (cmd == 3 && $urandom_range(0, 1) == 0) ? a : int'($urandom_range(0, 255));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      v = model(cmd, a, b, 1'($urandom));
      run_vec(v, stall, "rnd");
    end

    // Reset in the middle of a shift.
    run_vec(model(8, 0, 'hA5, 0), 0, "pre_rst");
    @(negedge clk);
    alu_cmd = 4'd7; inA = 8'd6; inB = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.rslt", 32'(rslt), 32'd0);
    chk("midrst.sc_o", 32'(sc_o), 32'd0);
    chk("midrst.pari", 32'(pari), 32'd0);
    chk("midrst.branch_bool", 32'(branch_bool), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("midrst.no_out_valid", 32'(cnt), 32'd0);

    // W=16 long shift.
    @(negedge clk);
    v16_cmd = 4'd6; v16_a = 16'd15; v16_b = 16'h0001; v16_in_valid = 1'b1;
    #1;
    chk("w16.in_ready", 32'(v16_in_ready), 32'd1);
    @(posedge clk);
    #1 v16_in_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!v16_out_valid && cnt < 64);
    chk("w16.latency", 32'(cnt), 32'd16);
    chk("w16.rslt", 32'(v16_rslt), 32'h8000);
    chk("w16.sc_o", 32'(v16_sc), 32'd0);
    chk("w16.pari", 32'(v16_pari), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
